// File: rtl/dyt_rf_pkg.sv
// rtl/dyt_rf_pkg.sv - shared constants, types and popcount for the dyt register file
package dyt_rf_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ADDR_W_E = 4;
  localparam int ADDR_W_I = 5;
  localparam int MAX_ENT  = 1 << ADDR_W_I;

  typedef logic [ADDR_W_I-1:0] rf_addr_t;
  typedef logic [XLEN_DEF-1:0] rf_word_t;

  function automatic logic [ADDR_W_I:0] popcount(input logic [MAX_ENT-1:0] v);
    logic [ADDR_W_I:0] c;
    c = '0;
    for (int i = 0; i < MAX_ENT; i++) begin
      c = c + {{ADDR_W_I{1'b0}}, v[i]};
    end
    return c;
  endfunction
endpackage

// File: rtl/dyt_rf_scoreboard.sv
// rtl/dyt_rf_scoreboard.sv - pending-write scoreboard: issue/write-back/flush update, iss_ready, pend_cnt
module dyt_rf_scoreboard
  import dyt_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_E,
  localparam int NENT = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic [NENT-1:0]   pending,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [NENT-1:0]    pend_q;
  logic [NENT-1:0]    pend_nxt;
  logic [MAX_ENT-1:0] pend_ext;
  logic               iss_fire;

  // Only registered state feeds iss_ready, keeping wb_*/iss_valid off this path.
  assign iss_ready = !pend_q[iss_addr] || (iss_addr == '0);
  assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0);

  always_comb begin
    pend_nxt = pend_q;
    if (wb_en && (wb_addr != '0)) pend_nxt[wb_addr] = 1'b0;
    if (iss_fire) pend_nxt[iss_addr] = 1'b1;
    if (flush) pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  assign pend_ext = MAX_ENT'(pend_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= '0;
      pend_cnt <= '0;
    end else begin
      pend_q   <= pend_nxt;
      pend_cnt <= (ADDR_W+1)'(popcount(pend_ext));
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/dyt_regfile_sb.sv
// rtl/dyt_regfile_sb.sv - parametrised integer register file with pending-write scoreboard
// Optional same-cycle write-to-read forwarding under macro DYT_RF_BYPASS_EN.
module dyt_regfile_sb
  import dyt_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_E,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int NENT = 1 << ADDR_W;

  logic [XLEN-1:0]   mem [NENT];
  logic [NENT-1:0]   pending;
  logic [ADDR_W-1:0] ra  [NUM_RD];

  dyt_rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .flush     (flush),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  // Entry 0 is reset and never written, so it is a constant zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NENT; i++) mem[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      mem[wb_addr] <= wb_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_ra
    assign ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*XLEN +: XLEN] = (ra[p] == '0) ? '0 : mem[ra[p]];
      rd_ready[p]             = !pending[ra[p]];
`ifdef DYT_RF_BYPASS_EN
      if (wb_en && (wb_addr == ra[p]) && (wb_addr != '0)) begin
        rd_data[p*XLEN +: XLEN] = wb_data;
        rd_ready[p]             = 1'b1;
      end
`endif
    end
  end

endmodule
